doorlock_ctrl: RTL and testbench

Key-entry sequencer for the DE0 door lock. It samples the 4-bit digit code produced by the one-hot switch decoder and assembles a 4-digit entry. On an enter press it compares the entry against the stored password and drives the door-open and lockout outputs, enforcing timed open and lockout windows. It sits between the switch decoder and the display and actuator logic.

---
 rtl/doorlock_ctrl_if.sv | 24 ++
 rtl/doorlock_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_doorlock_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/doorlock_ctrl_if.sv
// Door-lock key-entry bus: decoder/button inputs toward the sequencer and
// entry/status outputs toward the display and actuator logic.
interface doorlock_ctrl_if;
  logic [3:0]  num_h;
  logic        btn_enter;
  logic        btn_clear;
  logic        btn_set;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic        door_open;
  logic        locked_out;
  logic        err_pulse;
  logic [2:0]  fail_cnt;

  modport master (
    output num_h, btn_enter, btn_clear, btn_set,
    input  entry, digit_cnt, door_open, locked_out, err_pulse, fail_cnt
  );

  modport slave (
    input  num_h, btn_enter, btn_clear, btn_set,
    output entry, digit_cnt, door_open, locked_out, err_pulse, fail_cnt
  );
endinterface

// File: rtl/doorlock_ctrl.sv
// Door-lock key-entry sequencer: collects 4 BCD digits, checks the code, times the
// open and lockout windows. Optional feature macro: DOORLOCK_PWCHANGE_EN (password change in OPEN).
module doorlock_ctrl #(
  parameter logic [15:0] PASSWORD    = 16'h1234,
  parameter int unsigned OPEN_CYCLES = 32'd50_000_000,
  parameter int unsigned LOCK_CYCLES = 32'd250_000_000,
  parameter int unsigned MAX_FAIL    = 32'd3
) (
  input logic            clk,
  input logic            rst,
  doorlock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  // Timer counts down to zero, so a window of N clocks loads N-1.
  localparam logic [31:0] OPEN_LOAD  = 32'(OPEN_CYCLES - 32'd1);
  localparam logic [31:0] LOCK_LOAD  = 32'(LOCK_CYCLES - 32'd1);
  localparam logic [2:0]  FAIL_LIMIT = 3'(MAX_FAIL);

  state_t      state_r, state_nxt_s;
  logic [31:0] timer_r, timer_nxt_s;
  logic [3:0]  num_prev_r;
  logic        enter_prev_r;
  logic        clear_prev_r;
  logic [15:0] entry_r, entry_nxt_s;
  logic [2:0]  digit_cnt_r, digit_cnt_nxt_s;
  logic [2:0]  fail_cnt_r, fail_cnt_nxt_s;
  logic        err_pulse_r, err_pulse_nxt_s;
  logic        door_open_r;
  logic        locked_out_r;

  logic        key_ev_s;
  logic        enter_ev_s;
  logic        clear_ev_s;
  logic        set_ev_s;
  logic        pw_write_s;
  logic        entry_full_s;
  logic        match_s;
  logic        timer_done_s;
  logic [2:0]  fail_inc_s;
  logic [15:0] pw_s;

`ifdef DOORLOCK_PWCHANGE_EN
  logic        set_prev_r;
  logic [15:0] pw_r, pw_nxt_s;

  assign set_ev_s   = bus.btn_set & ~set_prev_r;
  assign pw_write_s = set_ev_s & entry_full_s & ~clear_ev_s;
  assign pw_s       = pw_r;

  // Set-button history and the writable password register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_prev_r <= 1'b0;
      pw_r       <= PASSWORD;
    end else begin
      set_prev_r <= bus.btn_set;
      pw_r       <= pw_nxt_s;
    end
  end
`else
  logic unused_set_s;

  assign unused_set_s = bus.btn_set;
  assign set_ev_s     = 1'b0;
  assign pw_write_s   = 1'b0;
  assign pw_s         = PASSWORD;
`endif

  // A key counts only when a digit appears after a no-key code.
  assign key_ev_s     = (bus.num_h <= 4'd9) && (num_prev_r > 4'd9);
  assign enter_ev_s   = bus.btn_enter & ~enter_prev_r;
  assign clear_ev_s   = bus.btn_clear & ~clear_prev_r;
  assign entry_full_s = (digit_cnt_r == 3'd4);
  assign match_s      = entry_full_s && (entry_r == pw_s);
  assign timer_done_s = (timer_r == 32'd0);
  assign fail_inc_s   = fail_cnt_r + 3'd1;

  // Input history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_prev_r   <= 4'hA;
      enter_prev_r <= 1'b0;
      clear_prev_r <= 1'b0;
    end else begin
      num_prev_r   <= bus.num_h;
      enter_prev_r <= bus.btn_enter;
      clear_prev_r <= bus.btn_clear;
    end
  end

  // State and window timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      timer_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
    end
  end

  // Next-state decision; clear outranks enter in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_ev_s) begin
          state_nxt_s = ST_IDLE;
        end else if (enter_ev_s) begin
          if (match_s) begin
            state_nxt_s = ST_OPEN;
          end else if (fail_inc_s == FAIL_LIMIT) begin
            state_nxt_s = ST_LOCKOUT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (clear_ev_s || timer_done_s || pw_write_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (timer_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOCKOUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Entry, counters, error pulse, timer reload and password update.
  always_comb begin
    entry_nxt_s     = entry_r;
    digit_cnt_nxt_s = digit_cnt_r;
    fail_cnt_nxt_s  = fail_cnt_r;
    err_pulse_nxt_s = 1'b0;
`ifdef DOORLOCK_PWCHANGE_EN
    pw_nxt_s        = pw_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (clear_ev_s) begin
          entry_nxt_s     = 16'h0000;
          digit_cnt_nxt_s = 3'd0;
        end else if (enter_ev_s) begin
          // Enter is judged on the existing entry; a same-cycle key is dropped.
          entry_nxt_s     = 16'h0000;
          digit_cnt_nxt_s = 3'd0;
          if (match_s) begin
            fail_cnt_nxt_s = 3'd0;
          end else begin
            fail_cnt_nxt_s  = fail_inc_s;
            err_pulse_nxt_s = 1'b1;
          end
        end else if (key_ev_s && !entry_full_s) begin
          entry_nxt_s     = {entry_r[11:0], bus.num_h};
          digit_cnt_nxt_s = digit_cnt_r + 3'd1;
        end else begin
          entry_nxt_s     = entry_r;
          digit_cnt_nxt_s = digit_cnt_r;
        end
      end
      ST_OPEN: begin
`ifdef DOORLOCK_PWCHANGE_EN
        if (clear_ev_s) begin
          entry_nxt_s     = 16'h0000;
          digit_cnt_nxt_s = 3'd0;
        end else if (set_ev_s) begin
          if (entry_full_s) begin
            pw_nxt_s        = entry_r;
            entry_nxt_s     = 16'h0000;
            digit_cnt_nxt_s = 3'd0;
          end else begin
            err_pulse_nxt_s = 1'b1;
          end
        end else if (timer_done_s) begin
          entry_nxt_s     = 16'h0000;
          digit_cnt_nxt_s = 3'd0;
        end else if (key_ev_s && !entry_full_s) begin
          entry_nxt_s     = {entry_r[11:0], bus.num_h};
          digit_cnt_nxt_s = digit_cnt_r + 3'd1;
        end else begin
          entry_nxt_s     = entry_r;
          digit_cnt_nxt_s = digit_cnt_r;
        end
`else
        if (clear_ev_s) begin
          entry_nxt_s     = 16'h0000;
          digit_cnt_nxt_s = 3'd0;
        end else begin
          entry_nxt_s     = entry_r;
          digit_cnt_nxt_s = digit_cnt_r;
        end
`endif
      end
      ST_LOCKOUT: begin
        if (timer_done_s) begin
          fail_cnt_nxt_s = 3'd0;
        end else begin
          fail_cnt_nxt_s = fail_cnt_r;
        end
      end
      default: begin
        entry_nxt_s     = 16'h0000;
        digit_cnt_nxt_s = 3'd0;
        fail_cnt_nxt_s  = 3'd0;
      end
    endcase

    if ((state_nxt_s == ST_OPEN) && (state_r != ST_OPEN)) begin
      timer_nxt_s = OPEN_LOAD;
    end else if ((state_nxt_s == ST_LOCKOUT) && (state_r != ST_LOCKOUT)) begin
      timer_nxt_s = LOCK_LOAD;
    end else if ((state_r != ST_IDLE) && !timer_done_s) begin
      timer_nxt_s = timer_r - 32'd1;
    end else begin
      timer_nxt_s = timer_r;
    end
  end

  // Registered outputs; status flags follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_r      <= 16'h0000;
      digit_cnt_r  <= 3'd0;
      fail_cnt_r   <= 3'd0;
      err_pulse_r  <= 1'b0;
      door_open_r  <= 1'b0;
      locked_out_r <= 1'b0;
    end else begin
      entry_r      <= entry_nxt_s;
      digit_cnt_r  <= digit_cnt_nxt_s;
      fail_cnt_r   <= fail_cnt_nxt_s;
      err_pulse_r  <= err_pulse_nxt_s;
      door_open_r  <= (state_nxt_s == ST_OPEN);
      locked_out_r <= (state_nxt_s == ST_LOCKOUT);
    end
  end

  assign bus.entry      = entry_r;
  assign bus.digit_cnt  = digit_cnt_r;
  assign bus.fail_cnt   = fail_cnt_r;
  assign bus.err_pulse  = err_pulse_r;
  assign bus.door_open  = door_open_r;
  assign bus.locked_out = locked_out_r;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Directed bench for doorlock_ctrl with OPEN_CYCLES=8, LOCK_CYCLES=16, MAX_FAIL=3.
module tb_doorlock_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  doorlock_ctrl_if bus();

  doorlock_ctrl #(
    .PASSWORD   (16'h1234),
    .OPEN_CYCLES(32'd8),
    .LOCK_CYCLES(32'd16),
    .MAX_FAIL   (32'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.num_h     = 4'hF;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    bus.btn_set   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    @(negedge clk);
    bus.num_h = d;
    @(negedge clk);
    bus.num_h = 4'hF;
  endtask

  task automatic press_enter();
    @(negedge clk);
    bus.btn_enter = 1'b1;
    @(negedge clk);
    bus.btn_enter = 1'b0;
  endtask

  task automatic press_clear();
    @(negedge clk);
    bus.btn_clear = 1'b1;
    @(negedge clk);
    bus.btn_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_checks++; if (bus.entry !== 16'h0000) begin n_fail++; $display("FAIL reset_entry: got %h want 0000", bus.entry); end
    n_checks++; if (bus.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_digit_cnt: got %0d want 0", bus.digit_cnt); end
    n_checks++; if (bus.fail_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_fail_cnt: got %0d want 0", bus.fail_cnt); end
    n_checks++; if ({bus.door_open, bus.locked_out, bus.err_pulse} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.door_open, bus.locked_out, bus.err_pulse}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_correct_code();
    int cyc;
    do_reset();
    key(4'd7);
    press_enter();
    n_checks++; if (bus.fail_cnt !== 3'd1) begin n_fail++; $display("FAIL pre_fail_cnt: got %0d want 1", bus.fail_cnt); end
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    n_checks++; if (bus.entry !== 16'h1234) begin n_fail++; $display("FAIL entry_1234: got %h want 1234", bus.entry); end
    n_checks++; if (bus.digit_cnt !== 3'd4) begin n_fail++; $display("FAIL digit_cnt_4: got %0d want 4", bus.digit_cnt); end
    press_enter();
    n_checks++; if (bus.door_open !== 1'b1) begin n_fail++; $display("FAIL open_latency: got %b want 1", bus.door_open); end
    n_checks++; if (bus.fail_cnt !== 3'd0) begin n_fail++; $display("FAIL open_fail_cnt: got %0d want 0", bus.fail_cnt); end
    n_checks++; if ({bus.entry, bus.digit_cnt} !== 19'd0) begin n_fail++; $display("FAIL open_entry_cleared: got %h/%0d want 0/0", bus.entry, bus.digit_cnt); end
    cyc = 0;
    while (bus.door_open === 1'b1 && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL open_duration: got %0d want 8", cyc); end
    @(negedge clk);
    n_checks++; if (bus.door_open !== 1'b0) begin n_fail++; $display("FAIL open_closed: got %b want 0", bus.door_open); end
  endtask

  task automatic test_wrong_code();
    do_reset();
    key(4'd1); key(4'd2); key(4'd3); key(4'd5);
    press_enter();
    n_checks++; if (bus.err_pulse !== 1'b1) begin n_fail++; $display("FAIL wrong_err: got %b want 1", bus.err_pulse); end
    n_checks++; if (bus.fail_cnt !== 3'd1) begin n_fail++; $display("FAIL wrong_fail_cnt: got %0d want 1", bus.fail_cnt); end
    n_checks++; if (bus.door_open !== 1'b0) begin n_fail++; $display("FAIL wrong_door: got %b want 0", bus.door_open); end
    @(negedge clk);
    n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", bus.err_pulse); end
    key(4'd1); key(4'd2);
    press_enter();
    n_checks++; if (bus.err_pulse !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b want 1", bus.err_pulse); end
    n_checks++; if (bus.fail_cnt !== 3'd2) begin n_fail++; $display("FAIL short_fail_cnt: got %0d want 2", bus.fail_cnt); end
    n_checks++; if ({bus.door_open, bus.locked_out} !== 2'b00) begin n_fail++; $display("FAIL short_flags: got %b want 00", {bus.door_open, bus.locked_out}); end
    n_checks++; if ({bus.entry, bus.digit_cnt} !== 19'd0) begin n_fail++; $display("FAIL short_entry: got %h/%0d want 0/0", bus.entry, bus.digit_cnt); end
  endtask

  task automatic test_lockout();
    do_reset();
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    press_enter();
    key(4'd1);
    press_enter();
    n_checks++; if (bus.locked_out !== 1'b0) begin n_fail++; $display("FAIL early_lockout: got %b want 0", bus.locked_out); end
    press_enter();
    n_checks++; if (bus.fail_cnt !== 3'd3) begin n_fail++; $display("FAIL lock_fail_cnt: got %0d want 3", bus.fail_cnt); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (bus.locked_out !== 1'b1) begin n_fail++; $display("FAIL lock_held_c%0d: got %b want 1", i, bus.locked_out); end
      n_checks++; if ({bus.door_open, bus.err_pulse, bus.entry, bus.digit_cnt} !== {1'b0, (i == 0), 19'd0}) begin
        n_fail++; $display("FAIL lock_ignore_c%0d: got door=%b err=%b entry=%h cnt=%0d", i, bus.door_open, bus.err_pulse, bus.entry, bus.digit_cnt);
      end
      case (i)
        0: bus.num_h = 4'd1;
        2: bus.num_h = 4'd2;
        4: bus.num_h = 4'd3;
        6: bus.num_h = 4'd4;
        8: bus.btn_enter = 1'b1;
        9: bus.btn_enter = 1'b0;
        10: bus.btn_clear = 1'b1;
        11: bus.btn_clear = 1'b0;
        default: bus.num_h = 4'hF;
      endcase
      @(negedge clk);
    end
    n_checks++; if (bus.locked_out !== 1'b0) begin n_fail++; $display("FAIL lock_release: got %b want 0", bus.locked_out); end
    n_checks++; if (bus.fail_cnt !== 3'd0) begin n_fail++; $display("FAIL lock_exit_fail_cnt: got %0d want 0", bus.fail_cnt); end
    n_checks++; if (bus.door_open !== 1'b0) begin n_fail++; $display("FAIL lock_exit_door: got %b want 0", bus.door_open); end
  endtask

  task automatic test_key_edges();
    do_reset();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    n_checks++; if (bus.digit_cnt !== 3'd4) begin n_fail++; $display("FAIL saturate_cnt: got %0d want 4", bus.digit_cnt); end
    n_checks++; if (bus.entry !== 16'h1234) begin n_fail++; $display("FAIL saturate_entry: got %h want 1234", bus.entry); end
    press_clear();
    n_checks++; if ({bus.entry, bus.digit_cnt, bus.err_pulse} !== 20'd0) begin n_fail++; $display("FAIL clear: got %h/%0d/%b want 0/0/0", bus.entry, bus.digit_cnt, bus.err_pulse); end
    @(negedge clk); bus.num_h = 4'd6;
    repeat (4) @(negedge clk);
    bus.num_h = 4'hF;
    @(negedge clk);
    n_checks++; if ({bus.entry, bus.digit_cnt} !== {16'h0006, 3'd1}) begin n_fail++; $display("FAIL held_key: got %h/%0d want 0006/1", bus.entry, bus.digit_cnt); end
    bus.num_h = 4'd3;
    @(negedge clk); bus.num_h = 4'd7;
    @(negedge clk); bus.num_h = 4'hF;
    @(negedge clk);
    n_checks++; if ({bus.entry, bus.digit_cnt} !== {16'h0063, 3'd2}) begin n_fail++; $display("FAIL direct_3_to_7: got %h/%0d want 0063/2", bus.entry, bus.digit_cnt); end
    bus.btn_enter = 1'b1; bus.num_h = 4'd4;
    @(negedge clk);
    bus.btn_enter = 1'b0; bus.num_h = 4'hF;
    n_checks++; if ({bus.err_pulse, bus.fail_cnt, bus.digit_cnt, bus.entry} !== {1'b1, 3'd1, 3'd0, 16'h0000}) begin
      n_fail++; $display("FAIL enter_with_key: got err=%b fail=%0d cnt=%0d entry=%h want 1/1/0/0000", bus.err_pulse, bus.fail_cnt, bus.digit_cnt, bus.entry);
    end
    key(4'd7); key(4'd8);
    @(negedge clk);
    bus.btn_enter = 1'b1; bus.btn_clear = 1'b1;
    @(negedge clk);
    bus.btn_enter = 1'b0; bus.btn_clear = 1'b0;
    n_checks++; if ({bus.entry, bus.digit_cnt, bus.err_pulse, bus.door_open} !== 21'd0) begin
      n_fail++; $display("FAIL clear_beats_enter: got entry=%h cnt=%0d err=%b door=%b want 0", bus.entry, bus.digit_cnt, bus.err_pulse, bus.door_open);
    end
    n_checks++; if (bus.fail_cnt !== 3'd1) begin n_fail++; $display("FAIL clear_keeps_fail_cnt: got %0d want 1", bus.fail_cnt); end
  endtask

  task automatic test_reset_mid_open();
    do_reset();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    press_enter();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.door_open !== 1'b1) begin n_fail++; $display("FAIL pre_reset_open: got %b want 1", bus.door_open); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.door_open !== 1'b0) begin n_fail++; $display("FAIL async_reset_door: got %b want 0", bus.door_open); end
    n_checks++; if ({bus.entry, bus.digit_cnt, bus.fail_cnt, bus.locked_out, bus.err_pulse} !== 24'd0) begin n_fail++; $display("FAIL async_reset_outputs: got nonzero"); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.door_open !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", bus.door_open); end
  endtask

`ifdef DOORLOCK_PWCHANGE_EN
  task automatic test_pwchange();
    do_reset();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    @(negedge clk); bus.btn_enter = 1'b1;
    @(negedge clk); bus.btn_enter = 1'b0; bus.num_h = 4'd5;
    @(negedge clk); bus.num_h = 4'hF;
    @(negedge clk); bus.num_h = 4'd6;
    @(negedge clk); bus.num_h = 4'hF;
    @(negedge clk); bus.num_h = 4'd7;
    @(negedge clk); bus.num_h = 4'hF;
    @(negedge clk); bus.num_h = 4'd8;
    @(negedge clk); bus.num_h = 4'hF;
    n_checks++; if ({bus.entry, bus.digit_cnt, bus.door_open} !== {16'h5678, 3'd4, 1'b1}) begin
      n_fail++; $display("FAIL pw_entry_in_open: got %h/%0d/%b want 5678/4/1", bus.entry, bus.digit_cnt, bus.door_open);
    end
    bus.btn_set = 1'b1;
    @(negedge clk); bus.btn_set = 1'b0;
    n_checks++; if ({bus.door_open, bus.entry, bus.digit_cnt} !== 20'd0) begin n_fail++; $display("FAIL pw_set_exit: got door=%b entry=%h cnt=%0d", bus.door_open, bus.entry, bus.digit_cnt); end
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    press_enter();
    n_checks++; if ({bus.door_open, bus.err_pulse} !== 2'b01) begin n_fail++; $display("FAIL old_pw_rejected: got door=%b err=%b want 0/1", bus.door_open, bus.err_pulse); end
    key(4'd5); key(4'd6); key(4'd7); key(4'd8);
    press_enter();
    n_checks++; if ({bus.door_open, bus.fail_cnt} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL new_pw_opens: got door=%b fail=%0d want 1/0", bus.door_open, bus.fail_cnt); end
  endtask
`else
  task automatic test_set_ignored();
    do_reset();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    press_enter();
    key(4'd5);
    n_checks++; if ({bus.entry, bus.digit_cnt} !== 19'd0) begin n_fail++; $display("FAIL open_key_ignored: got %h/%0d want 0/0", bus.entry, bus.digit_cnt); end
    @(negedge clk); bus.btn_set = 1'b1;
    @(negedge clk); bus.btn_set = 1'b0;
    n_checks++; if ({bus.door_open, bus.err_pulse} !== 2'b10) begin n_fail++; $display("FAIL set_ignored: got door=%b err=%b want 1/0", bus.door_open, bus.err_pulse); end
    repeat (8) @(negedge clk);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    press_enter();
    n_checks++; if (bus.door_open !== 1'b1) begin n_fail++; $display("FAIL pw_unchanged: got %b want 1", bus.door_open); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_lockout();
    test_key_edges();
    test_reset_mid_open();
`ifdef DOORLOCK_PWCHANGE_EN
    test_pwchange();
`else
    test_set_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
